wave_ram_nch: RTL

//  Multi-channel wavetable sample source: writable sample RAM (sync read, read-first) plus
//  NUM_CH phase accumulators serviced round-robin, one RAM read per clock. Sits between the

---
 rtl/wave_ram_pkg.sv | 17 +
 rtl/wave_ram_core.sv | 32 +++
 rtl/wave_ram_nch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wave_ram_pkg.sv
// rtl/wave_ram_pkg.sv - default widths and shared types for the wavetable sample source
package wave_ram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int NUM_CH     = 4;
  localparam int CH_WIDTH   = 2;
  localparam int FRAC_WIDTH = 8;

  function automatic int calc_ph_w(input int aw, input int fw);
    return aw + fw;
  endfunction

  localparam int PH_W = calc_ph_w(ADDR_WIDTH, FRAC_WIDTH);

  typedef logic [PH_W-1:0]       phase_t;
  typedef logic [DATA_WIDTH-1:0] sample_t;
endpackage

// File: rtl/wave_ram_core.sv
// rtl/wave_ram_core.sv - sample table RAM, one write port, one registered read-first read port
module wave_ram_core
  import wave_ram_pkg::*;
#(
  parameter int P_DATA_WIDTH = wave_ram_pkg::DATA_WIDTH,
  parameter int P_ADDR_WIDTH = wave_ram_pkg::ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [P_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [P_DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_rd_en,
  input  logic [P_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [P_DATA_WIDTH-1:0] o_rd_data
);
  logic [P_DATA_WIDTH-1:0] r_mem [1<<P_ADDR_WIDTH];
  logic [P_DATA_WIDTH-1:0] r_rd_data;

  // Table contents are not reset; loader fills them after power-up.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Nonblocking read of the array gives the old word on a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/wave_ram_nch.sv
// rtl/wave_ram_nch.sv - NUM_CH round-robin phase accumulators reading one shared wavetable
// Optional OUT_REG_EN adds a second output register stage (latency 2).
module wave_ram_nch
  import wave_ram_pkg::*;
#(
  parameter int DATA_WIDTH = wave_ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wave_ram_pkg::ADDR_WIDTH,
  parameter int NUM_CH     = wave_ram_pkg::NUM_CH,
  parameter int CH_WIDTH   = wave_ram_pkg::CH_WIDTH,
  parameter int FRAC_WIDTH = wave_ram_pkg::FRAC_WIDTH,
  localparam int LP_PH_W   = calc_ph_w(ADDR_WIDTH, FRAC_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  step_we,
  input  logic [CH_WIDTH-1:0]   step_ch,
  input  logic [LP_PH_W-1:0]    step_val,
  input  logic                  run,
  input  logic                  phase_clr,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic [CH_WIDTH-1:0]   sample_ch,
  output logic                  sample_valid,
  output logic                  sample_wrap
);
  logic [LP_PH_W-1:0]    r_step  [NUM_CH];
  logic [LP_PH_W-1:0]    r_phase [NUM_CH];
  logic [CH_WIDTH-1:0]   r_ch_cnt;
  logic [CH_WIDTH-1:0]   r_s1_ch;
  logic                  r_s1_valid;
  logic                  r_s1_wrap;

  logic [LP_PH_W-1:0]    w_cur_phase;
  logic [LP_PH_W-1:0]    w_cur_step;
  logic [LP_PH_W:0]      w_sum;
  logic                  w_issue;
  logic                  w_step_ok;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_s1_data;

  assign w_cur_phase = r_phase[r_ch_cnt];
  assign w_cur_step  = r_step[r_ch_cnt];
  assign w_sum       = {1'b0, w_cur_phase} + {1'b0, w_cur_step};
  assign w_issue     = run & ~phase_clr;
  assign w_step_ok   = (32'(step_ch) < NUM_CH);
  assign w_rd_addr   = w_cur_phase[LP_PH_W-1:FRAC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_step[i]  <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (step_we && w_step_ok && step_ch == CH_WIDTH'(i)) r_step[i] <= step_val;
        if (phase_clr)
          r_phase[i] <= '0;
        else if (w_issue && r_ch_cnt == CH_WIDTH'(i))
          r_phase[i] <= w_sum[LP_PH_W-1:0];
      end
      if (phase_clr)
        r_ch_cnt <= '0;
      else if (w_issue)
        r_ch_cnt <= (r_ch_cnt == CH_WIDTH'(NUM_CH-1)) ? '0 : r_ch_cnt + 1'b1;
    end
  end

  // Channel tag and wrap flag travel alongside the RAM read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_ch    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_wrap  <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_wrap  <= w_issue & w_sum[LP_PH_W];
      if (w_issue) r_s1_ch <= r_ch_cnt;
    end
  end

  wave_ram_core #(
    .P_DATA_WIDTH (DATA_WIDTH),
    .P_ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_issue),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_s1_data)
  );

`ifdef OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic [CH_WIDTH-1:0]   r_s2_ch;
  logic                  r_s2_valid;
  logic                  r_s2_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_data  <= '0;
      r_s2_ch    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_wrap  <= 1'b0;
    end else begin
      r_s2_data  <= w_s1_data;
      r_s2_ch    <= r_s1_ch;
      r_s2_valid <= r_s1_valid;
      r_s2_wrap  <= r_s1_wrap;
    end
  end

  assign sample_data  = r_s2_data;
  assign sample_ch    = r_s2_ch;
  assign sample_valid = r_s2_valid;
  assign sample_wrap  = r_s2_wrap;
`else
  assign sample_data  = w_s1_data;
  assign sample_ch    = r_s1_ch;
  assign sample_valid = r_s1_valid;
  assign sample_wrap  = r_s1_wrap;
`endif
endmodule
